mdu_scheduler: RTL and testbench
================================

Name: mdu_scheduler

Overview:
- Multiply/divide unit for the 5-stage MIPS pipeline, sitting beside the ALU in the E stage.
- Owns the HI/LO registers and sequences the multi-cycle mult/multu/div/divu busy period.
- Performs mthi/mtlo writes and returns HI or LO for mfhi/mflo.
- Issues the E-stage stall request to the hazard unit and honours the exception/interrupt flush (Req) from CP0.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high; clears all state.
- Req  in  1  exception/interrupt taken this cycle; the E-stage instruction is being flushed.
- MDOp_E  in  4  decoded E-stage MD operation (package encoding; NONE = 0).
- RS_E  in  32  forwarded rs operand.
- RT_E  in  32  forwarded rt operand.
- Busy  out  1  multi-cycle operation in progress.
- Stall_E  out  1  freeze F/D/E and insert bubble into M.
- MDOut_E  out  32  HI for MFHI, LO for MFLO, 0 otherwise.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

Behaviour:
- Reset: HI = LO = 0, Busy = 0, counter = 0, pending registers = 0, Stall_E = 0. Applies asynchronously, including mid-operation; the pending result is discarded.
- Start = (MDOp_E is MULT/MULTU/DIV/DIVU) && !Busy && !Req.
  - When Start is asserted in cycle t, the result is computed from RS_E/RT_E in cycle t and latched into pending HI/LO.
  - The counter loads N (MULT_CYCLES or DIV_CYCLES).
  - Busy is high for cycles t+1 .. t+N.
  - On the edge ending cycle t+N, pending values are written to HI/LO and Busy falls. New values are visible in cycle t+N+1.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned.
  - Divide by zero (RT_E = 0): the operation still takes DIV_CYCLES, but HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - Write RS_E into HI/LO at the end of the cycle when !Busy && !Req.
  - Blocked by Stall_E while Busy.
- MFHI/MFLO: MDOut_E is combinational from the current HI/LO.
- Stall_E = (MDOp_E != NONE) && (Busy || Start).
  - Consequence: the MD op issued in cycle t stalls no following MD op in cycle t itself, because Start is computed from the E-stage instruction only.
  - A following MD op reaching E during t+1 .. t+N stalls.
  - The first non-stalled cycle is t+N+1, and that op sees the updated HI/LO.
- Req:
  - Suppresses Start and MTHI/MTLO writes in the same cycle.
  - Does not cancel an operation already Busy; the earlier instruction has committed.
- Simultaneous events:
  - Completion edge and MTHI in the same cycle cannot occur, because MTHI is stalled while Busy.
  - Start while Busy is impossible by construction.
- Non-MD MDOp_E values have no effect on HI/LO.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, adds MADD, MADDU, MSUB, MSUBU, for MULT_CYCLES each.
  - The pending result is {HI,LO} plus (or minus) the signed/unsigned 64-bit product.
  - The {HI,LO} operand is sampled at Start, which is safe because no write is outstanding when Start fires.
  - These ops stall like the other MD ops.
- When not defined, these encodings are treated as NONE: no Start, no stall, HI/LO untouched.

Decomposition:
- Shared header (with the existing opcode defines): MDOp encodings.
  - NONE 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MTHI 5, MTLO 6, MFHI 7, MFLO 8, MADD 9, MADDU 10, MSUB 11, MSUBU 12.
  - Also default cycle counts.
- One sub-module, mdu_busy_counter:
  - 4-bit down-counter with load/value inputs.
  - Outputs Busy and a done pulse on the final busy cycle.
- Arithmetic and the HI/LO registers stay in the top block.
- Decoding of MDOp_E stays in the existing E-stage controller.

Test Plan:
- MULT, RS=0xFFFFFFFE (-2), RT=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. A back-to-back MFLO stalls 5 cycles, then reads 0xFFFFFFFA.
- DIVU, RS=7, RT=2 -> Busy 10 cycles; LO=3, HI=1. DIV, RS=-7, RT=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with RT=0, prior HI=0x11, LO=0x22 -> Busy 10 cycles, then HI/LO remain 0x11/0x22.
- MULT issued with Req=1 -> Busy stays 0, Stall_E=0, HI/LO unchanged. MTHI with Req=1 -> HI unchanged.
- MULT started, reset asserted on busy cycle 3 -> Busy=0 and HI=LO=0 immediately; the pending result is never written.
- With MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, then MADDU with 1*1 -> HI=1, LO=0 after 5 cycles. Without the macro the same op leaves HI/LO unchanged with Stall_E=0.

Source files
------------

// File: rtl/mdu_scheduler_pkg.sv
// Shared MD operation encodings and default busy-period lengths for the E-stage multiply/divide unit.
// MADD/MADDU/MSUB/MSUBU encodings are only honoured when MDU_MADD_EN is defined.
package mdu_scheduler_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_t;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_busy_counter.sv
// Busy-period down-counter: loads the operation length on start and counts down to idle.
module mdu_busy_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic       busy,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    // done marks the last busy cycle, so the HI/LO commit lands on the edge that ends it
    assign busy = (count != 4'd0);
    assign done = (count == 4'd1);

endmodule

// File: rtl/mdu_scheduler.sv
// E-stage multiply/divide unit: owns HI/LO, sequences the multi-cycle busy period and raises Stall_E.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MADD_EN.
module mdu_scheduler
    import mdu_scheduler_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  MDOp_E,
    input  logic [31:0] RS_E,
    input  logic [31:0] RT_E,
    output logic        Busy,
    output logic        Stall_E,
    output logic [31:0] MDOut_E,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic        is_mul;
    logic        is_div;
    logic        is_acc;
    logic        is_move;
    logic        start;
    logic        done;
    logic        div_signed;
    logic [3:0]  load_value;

    logic [63:0] rs_sext;
    logic [63:0] rt_sext;
    logic [63:0] sprod;
    logic [63:0] uprod;

    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    logic [63:0] next_pending;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;
    logic        pending_we;

    always_comb begin
        is_mul  = (MDOp_E == MD_MULT) || (MDOp_E == MD_MULTU);
        is_div  = (MDOp_E == MD_DIV)  || (MDOp_E == MD_DIVU);
        is_move = (MDOp_E == MD_MTHI) || (MDOp_E == MD_MTLO) ||
                  (MDOp_E == MD_MFHI) || (MDOp_E == MD_MFLO);
`ifdef MDU_MADD_EN
        is_acc  = (MDOp_E == MD_MADD) || (MDOp_E == MD_MADDU) ||
                  (MDOp_E == MD_MSUB) || (MDOp_E == MD_MSUBU);
`else
        is_acc  = 1'b0;
`endif
    end

    assign start      = (is_mul || is_div || is_acc) && !Busy && !Req;
    assign Stall_E    = (is_mul || is_div || is_acc || is_move) && (Busy || start);
    assign load_value = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

    mdu_busy_counter u_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (start),
        .load_value (load_value),
        .busy       (Busy),
        .done       (done)
    );

    // Both products are formed at 64 bits; the signed one from sign-extended operands
    always_comb begin
        rs_sext = {{32{RS_E[31]}}, RS_E};
        rt_sext = {{32{RT_E[31]}}, RT_E};
        sprod   = rs_sext * rt_sext;
        uprod   = {32'd0, RS_E} * {32'd0, RT_E};
    end

    // Signed divide runs on magnitudes, so -2^31 / -1 wraps cleanly instead of overflowing
    always_comb begin
        div_signed = (MDOp_E == MD_DIV);
        rs_neg     = div_signed && RS_E[31];
        rt_neg     = div_signed && RT_E[31];
        dividend   = rs_neg ? (32'd0 - RS_E) : RS_E;
        divisor    = rt_neg ? (32'd0 - RT_E) : RT_E;
        if (divisor == 32'd0) begin
            divisor = 32'd1;
        end
        quot_mag   = dividend / divisor;
        rem_mag    = dividend % divisor;
        quot       = (rs_neg ^ rt_neg) ? (32'd0 - quot_mag) : quot_mag;
        rem        = rs_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        next_pending = 64'd0;
        case (MDOp_E)
            MD_MULT:  next_pending = sprod;
            MD_MULTU: next_pending = uprod;
            MD_DIV,
            MD_DIVU:  next_pending = {rem, quot};
`ifdef MDU_MADD_EN
            MD_MADD:  next_pending = {HI, LO} + sprod;
            MD_MADDU: next_pending = {HI, LO} + uprod;
            MD_MSUB:  next_pending = {HI, LO} - sprod;
            MD_MSUBU: next_pending = {HI, LO} - uprod;
`endif
            default:  next_pending = 64'd0;
        endcase
    end

    // A divide by zero still occupies the unit but never commits its pending result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI         <= 32'd0;
            LO         <= 32'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_we <= 1'b0;
        end else begin
            if (start) begin
                pending_hi <= next_pending[63:32];
                pending_lo <= next_pending[31:0];
                pending_we <= !(is_div && (RT_E == 32'd0));
            end
            if (done && pending_we) begin
                HI <= pending_hi;
                LO <= pending_lo;
            end else if (!Busy && !Req) begin
                if (MDOp_E == MD_MTHI) begin
                    HI <= RS_E;
                end
                if (MDOp_E == MD_MTLO) begin
                    LO <= RS_E;
                end
            end
        end
    end

    always_comb begin
        MDOut_E = 32'd0;
        if (MDOp_E == MD_MFHI) begin
            MDOut_E = HI;
        end else if (MDOp_E == MD_MFLO) begin
            MDOut_E = LO;
        end
    end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mdu_scheduler;
    import mdu_scheduler_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        req;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        stall;
    logic [31:0] mdOut;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [31:0] pHi;
    logic [31:0] pLo;
    bit          pWe;
    int          cycleNum;
    int          doneCycle;

    logic        obsStall;
    logic        obsBusy;
    logic [31:0] obsOut;

    mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .Req     (req),
        .MDOp_E  (op),
        .RS_E    (rs),
        .RT_E    (rt),
        .Busy    (busy),
        .Stall_E (stall),
        .MDOut_E (mdOut),
        .HI      (hi),
        .LO      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit accEnabled();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit isStartOp(input logic [3:0] o);
        if (o >= 4'd1 && o <= 4'd4) return 1'b1;
        if (o >= 4'd9 && o <= 4'd12) return accEnabled();
        return 1'b0;
    endfunction

    function automatic bit isMdOp(input logic [3:0] o);
        if (o >= 4'd1 && o <= 4'd8) return 1'b1;
        return isStartOp(o);
    endfunction

    // Architectural results from plain 64-bit integer arithmetic
    function automatic void modelCompute(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] h, input logic [31:0] l,
                                         output logic [63:0] res, output bit we);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = 64'd0;
        we  = 1'b1;
        case (o)
            4'd1: res = 64'(sa * sb);
            4'd2: res = 64'(ua * ub);
            4'd3: if (b == 32'd0) we = 1'b0; else res = {32'(sa % sb), 32'(sa / sb)};
            4'd4: if (b == 32'd0) we = 1'b0; else res = {32'(ua % ub), 32'(ua / ub)};
            4'd9:  res = {h, l} + 64'(sa * sb);
            4'd10: res = {h, l} + 64'(ua * ub);
            4'd11: res = {h, l} - 64'(sa * sb);
            4'd12: res = {h, l} - 64'(ua * ub);
            default: we = 1'b0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
        op  = o;
        rs  = a;
        rt  = b;
        req = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mHi       = 32'd0;
        mLo       = 32'd0;
        pWe       = 1'b0;
        doneCycle = -1;
    endtask

    // One pipeline cycle: compare mid-cycle, then advance the model across the rising edge
    task automatic runCycle();
        bit          expBusy;
        bit          expStart;
        bit          expStall;
        logic [31:0] expOut;
        logic [63:0] res;
        bit          we;
        @(negedge clk);
        expBusy  = (cycleNum <= doneCycle);
        expStart = isStartOp(op) && !expBusy && !req;
        expStall = isMdOp(op) && (expBusy || expStart);
        expOut   = (op == 4'd7) ? mHi : (op == 4'd8) ? mLo : 32'd0;
        obsStall = stall;
        obsBusy  = busy;
        obsOut   = mdOut;
        checkOutput("busy",  {31'd0, busy},  {31'd0, expBusy});
        checkOutput("stall", {31'd0, stall}, {31'd0, expStall});
        checkOutput("mdout", mdOut, expOut);
        checkOutput("hi",    hi,    mHi);
        checkOutput("lo",    lo,    mLo);
        @(posedge clk);
        if (expBusy && cycleNum == doneCycle && pWe) begin
            mHi = pHi;
            mLo = pLo;
        end
        if (expStart) begin
            modelCompute(op, rs, rt, mHi, mLo, res, we);
            pHi       = res[63:32];
            pLo       = res[31:0];
            pWe       = we;
            doneCycle = cycleNum + ((op == 4'd3 || op == 4'd4) ? DC : MC);
        end
        if (!expBusy && !req && op == 4'd5) mHi = rs;
        if (!expBusy && !req && op == 4'd6) mLo = rs;
        cycleNum++;
        #1;
    endtask

    task automatic runIdle(input int n, output int busyCount);
        busyCount = 0;
        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < n; i++) begin
            runCycle();
            if (obsBusy) busyCount++;
        end
    endtask

    initial begin
        int          stallCount;
        int          busyCount;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        cycleNum = 0;
        modelReset();
        #2;
        checkOutput("reset_busy",  {31'd0, busy},  32'd0);
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_hi",    hi, 32'd0);
        checkOutput("reset_lo",    lo, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // MULT -2 * 3 followed by a dependent MFLO
        applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        runCycle();
        applyStimulus(4'd8, 32'd0, 32'd0, 1'b0);
        stallCount = 0;
        for (int i = 0; i < 20; i++) begin
            runCycle();
            if (!obsStall) break;
            stallCount++;
        end
        checkOutput("mult_mflo_stalls", 32'(stallCount), 32'd5);
        checkOutput("mult_mflo_value", obsOut, 32'hFFFFFFFA);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFA);

        // DIVU 7 / 2
        applyStimulus(4'd4, 32'd7, 32'd2, 1'b0);
        runCycle();
        runIdle(11, busyCount);
        checkOutput("divu_busy_cycles", 32'(busyCount), 32'd10);
        checkOutput("divu_hi", hi, 32'd1);
        checkOutput("divu_lo", lo, 32'd3);

        // DIV -7 / 2
        applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        runCycle();
        runIdle(11, busyCount);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);

        // Divide by zero keeps the prior HI/LO
        applyStimulus(4'd5, 32'h11, 32'd0, 1'b0);
        runCycle();
        applyStimulus(4'd6, 32'h22, 32'd0, 1'b0);
        runCycle();
        applyStimulus(4'd3, 32'd1234, 32'd0, 1'b0);
        runCycle();
        runIdle(11, busyCount);
        checkOutput("div0_busy_cycles", 32'(busyCount), 32'd10);
        checkOutput("div0_hi", hi, 32'h11);
        checkOutput("div0_lo", lo, 32'h22);

        // Req suppresses both a start and an MTHI write
        applyStimulus(4'd1, 32'd9, 32'd9, 1'b1);
        runCycle();
        checkOutput("req_mult_stall", {31'd0, obsStall}, 32'd0);
        applyStimulus(4'd5, 32'hDEAD, 32'd0, 1'b1);
        runCycle();
        runIdle(1, busyCount);
        checkOutput("req_busy", 32'(busyCount), 32'd0);
        checkOutput("req_hi", hi, 32'h11);
        checkOutput("req_lo", lo, 32'h22);

        // MADDU 1*1 onto {0, 0xFFFFFFFF}
        applyStimulus(4'd5, 32'd0, 32'd0, 1'b0);
        runCycle();
        applyStimulus(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
        runCycle();
        applyStimulus(4'd10, 32'd1, 32'd1, 1'b0);
        runCycle();
        checkOutput("maddu_stall", {31'd0, obsStall}, {31'd0, accEnabled()});
        runIdle(6, busyCount);
`ifdef MDU_MADD_EN
        checkOutput("maddu_hi", hi, 32'd1);
        checkOutput("maddu_lo", lo, 32'd0);
`else
        checkOutput("maddu_hi", hi, 32'd0);
        checkOutput("maddu_lo", lo, 32'hFFFFFFFF);
`endif

        // Reset on busy cycle 3 of a MULT discards the pending result
        applyStimulus(4'd1, 32'd100, 32'd200, 1'b0);
        runCycle();
        runIdle(2, busyCount);
        reset = 1'b1;
        #1;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_hi", hi, 32'd0);
        checkOutput("midreset_lo", lo, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycleNum++;
        runIdle(6, busyCount);
        checkOutput("midreset_no_commit", lo, 32'd0);

        // Random traffic, including undefined encodings and occasional Req
        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, ($urandom_range(0, 9) == 0));
            runCycle();
        end
        runIdle(12, busyCount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
